bottomhalf_bus_master: RTL and testbench
========================================

# bottomhalf_bus_master

Synthesizable initiator for the FPGA bottom-half parallel bus (8-bit multiplexed data, ALE, active-low WRITE and READ strobes). It converts single-beat register requests into properly timed address-latch, write, and read strobe sequences. It also captures read data from the responder. It sits on the controller side of the bus and drives a bottom-half responder: either a chained FPGA or a simulation model of the programmer's microcontroller.

## Interface
Parameters:
- `PULSE_CYCLES`, default 2: width of the ALE-high, WRITE-low, and READ-low pulses, in clocks; ≥1.
- `SETUP_CYCLES`, default 1: address hold, data setup, bus turnaround, and strobe recovery, in clocks; ≥1.
- `ADDR_CACHE`, default 1: when 1, skip the address phase if `req_addr` equals the last latched address.

Ports:
- `__osc`, in, 1: clock (24 MHz).
- `__rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: master idle and accepting.
- `req_write`, in, 1: 1 selects write, 0 selects read.
- `req_addr`, in, 8: bus address, latched by the responder on ALE fall.
- `req_wdata`, in, 8: write data.
- `rsp_valid`, out, 1: one-cycle completion pulse, for both reads and writes.
- `rsp_rdata`, out, 8: read data; holds its value until the next read completes.
- `bus_data_out`, out, 8: value driven onto the data bus.
- `bus_data_oe`, out, 1: data bus output enable; the top level instantiates the tristate buffers.
- `bus_data_in`, in, 8: data bus input.
- `bus_ale`, out, 1: address latch enable; idle level is low.
- `bus_write`, out, 1: write strobe, active-low; idle level is high.
- `bus_read`, out, 1: read strobe, active-low; idle level is high.

## Operation
- All bus outputs are registered. Reset values:
  - `bus_ale`=0, `bus_write`=1, `bus_read`=1.
  - `bus_data_oe`=0, `bus_data_out`=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0.
  - Address cache invalid.
- A request is accepted when `req_valid && req_ready`. `req_ready` drops in the next cycle. The request fields are registered at acceptance.
- FSM states: IDLE, ALE_HI, ALE_HOLD, WR_SETUP, WR_LOW, WR_HOLD, RD_TURN, RD_LOW, RECOVER, DONE.
  - A single down-counter, loaded on each state entry, times every phase.
- Address phase. Entered when the cache is invalid, when the address differs from the cached one, or when `ADDR_CACHE`=0.
  - ALE_HI (P cycles): `oe`=1, `data_out`=addr, `ale`=1.
  - ALE_HOLD (S cycles): `ale`=0, addr still driven.
  - On ALE_HOLD exit, the cache stores addr and becomes valid.
- Write phase:
  - WR_SETUP (S cycles): `data_out`=wdata, `oe`=1.
  - WR_LOW (P cycles): `write`=0.
  - WR_HOLD (S cycles): `write`=1, wdata still driven.
  - Then DONE.
- Read phase:
  - RD_TURN (S cycles): `oe`=0, turnaround.
  - RD_LOW (P cycles): `read`=0. `bus_data_in` is registered into `rsp_rdata` at the clock edge ending the last RD_LOW cycle.
  - RECOVER (S cycles): `read`=1, `oe`=0.
  - Then DONE.
- DONE (1 cycle): `rsp_valid`=1, `oe`=0, `req_ready` returns to 1 in the following cycle. The bus is released in DONE/IDLE.
- Strobes never overlap. At most one of {`ale`=1, `write`=0, `read`=0} is true in any cycle.
- `bus_data_oe`=1 is never concurrent with `bus_read`=0.
- Reset asserted mid-operation:
  - All outputs immediately return to their idle/reset values.
  - The cache is invalidated, so the next request always performs the address phase.
  - No `rsp_valid` is issued for the aborted request.
- Changes to `req_*` while `req_ready`=0 are ignored.

## Timing
- With P=`PULSE_CYCLES` and S=`SETUP_CYCLES`, for acceptance at clock edge k:
  - The first bus phase is visible in cycle k+1.
  - Write with address phase: `rsp_valid` in cycle k+1+2P+3S. Defaults (P=2, S=1): cycle k+8.
  - Write, cache hit: `rsp_valid` in cycle k+1+P+2S.
  - Read with address phase: `rsp_valid` in cycle k+1+2P+3S.
  - Read, cache hit: `rsp_valid` in cycle k+1+P+2S.
- Maximum throughput: one request per (latency+1) cycles. There is no pipelining.
- Responder contract: the responder drives read data from the READ falling edge. P≥1 guarantees at least one full clock of valid data before the sample edge.

## Structure
- Shared package `bottomhalf_pkg` holds:
  - `ADDR_OK_BIT`=4.
  - Identification addresses `8'hFD`/`8'hFE`/`8'hFF` (type low, type high, subtype).
  - State enum `bh_master_state_t`.
- Sub-module `bh_phase_timer`: a loadable down-counter whose width is derived from max(P,S), with a `done` output. One instance is used.

## Test plan
- Write addr 0x12, data 0xA5, defaults:
  - ALE high exactly 2 cycles with bus=0x12.
  - WRITE low exactly 2 cycles with bus=0xA5.
  - `rsp_valid` at k+8.
  - The responder model's register 0x12 reads back 0xA5.
- Read addr 0xFD against a responder model with type 0x1234:
  - `rsp_rdata`=0x34.
  - `oe`=0 throughout READ low.
  - `rsp_valid` at k+8.
- Back-to-back writes to 0x13 with `ADDR_CACHE`=1:
  - The second request produces no ALE pulse and completes at k+5.
  - With `ADDR_CACHE`=0, both requests pulse ALE.
- Assert `__rst_n` during WR_LOW:
  - `bus_write`=1 and `oe`=0 with no clock edge.
  - No `rsp_valid`.
  - The next request to the same address issues ALE.
- P=1, S=3 parameter sweep with random read/write traffic:
  - Strobe widths and latencies match the formulas.
  - Strobes never overlap.
  - `req_valid` held high while busy is accepted exactly once per completion.

Source files
------------

// File: rtl/bottomhalf_pkg.sv
// rtl/bottomhalf_pkg.sv - shared constants and types for the bottom-half bus
package bottomhalf_pkg;

    localparam int ADDR_OK_BIT = 4;

    localparam logic [7:0] ADDR_ID_TYPE_LO = 8'hFD;
    localparam logic [7:0] ADDR_ID_TYPE_HI = 8'hFE;
    localparam logic [7:0] ADDR_ID_SUBTYPE = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ALE_HI,
        ST_ALE_HOLD,
        ST_WR_SETUP,
        ST_WR_LOW,
        ST_WR_HOLD,
        ST_RD_TURN,
        ST_RD_LOW,
        ST_RECOVER,
        ST_DONE
    } bh_master_state_t;

    function automatic int bh_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter holds (cycles - 1), so max_count values need only clog2(max_count) bits.
    function automatic int bh_cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/bh_phase_timer.sv
// rtl/bh_phase_timer.sv - loadable down-counter timing each bus phase
module bh_phase_timer
    import bottomhalf_pkg::*;
#(
    parameter int MAX_COUNT = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_load,
    input  logic [bh_cnt_width(MAX_COUNT)-1:0]  i_load_val,
    output logic                                o_done
);

    localparam int CNT_W = bh_cnt_width(MAX_COUNT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/bottomhalf_bus_master.sv
// rtl/bottomhalf_bus_master.sv - single-beat initiator for the bottom-half parallel bus
module bottomhalf_bus_master
    import bottomhalf_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int ADDR_CACHE   = 1
) (
    input  logic       __osc,
    input  logic       __rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_in,
    output logic       bus_ale,
    output logic       bus_write,
    output logic       bus_read
);

    localparam int MAX_COUNT = bh_max(PULSE_CYCLES, SETUP_CYCLES);
    localparam int CNT_W     = bh_cnt_width(MAX_COUNT);
    localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(SETUP_CYCLES - 1);

    bh_master_state_t r_state;
    bh_master_state_t w_next_state;

    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic [7:0] r_bus_data_out;
    logic       r_bus_data_oe;
    logic       r_bus_ale;
    logic       r_bus_write;
    logic       r_bus_read;

    logic       r_op_write;
    logic [7:0] r_op_addr;
    logic [7:0] r_op_wdata;
    logic       r_cache_valid;
    logic [7:0] r_cache_addr;

    logic             w_accept;
    logic             w_addr_hit;
    logic             w_timer_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [7:0]       w_addr;
    logic [7:0]       w_wdata;
    logic [7:0]       w_data_out;
    logic             w_data_oe;
    logic             w_ale;
    logic             w_write;
    logic             w_read;

    assign w_accept   = req_valid && r_req_ready;
    assign w_addr_hit = (ADDR_CACHE != 0) && r_cache_valid && (req_addr == r_cache_addr);

    // Outputs are decoded from the next state so they appear registered in the state's first cycle.
    assign w_addr  = w_accept ? req_addr  : r_op_addr;
    assign w_wdata = w_accept ? req_wdata : r_op_wdata;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_addr_hit)    w_next_state = ST_ALE_HI;
                    else if (req_write) w_next_state = ST_WR_SETUP;
                    else                w_next_state = ST_RD_TURN;
                end
            end
            ST_ALE_HI:   if (w_timer_done) w_next_state = ST_ALE_HOLD;
            ST_ALE_HOLD: if (w_timer_done) w_next_state = r_op_write ? ST_WR_SETUP : ST_RD_TURN;
            ST_WR_SETUP: if (w_timer_done) w_next_state = ST_WR_LOW;
            ST_WR_LOW:   if (w_timer_done) w_next_state = ST_WR_HOLD;
            ST_WR_HOLD:  if (w_timer_done) w_next_state = ST_DONE;
            ST_RD_TURN:  if (w_timer_done) w_next_state = ST_RD_LOW;
            ST_RD_LOW:   if (w_timer_done) w_next_state = ST_RECOVER;
            ST_RECOVER:  if (w_timer_done) w_next_state = ST_DONE;
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (w_next_state != r_state);
        w_load_val = '0;
        case (w_next_state)
            ST_ALE_HI, ST_WR_LOW, ST_RD_LOW:                         w_load_val = P_LOAD;
            ST_ALE_HOLD, ST_WR_SETUP, ST_WR_HOLD, ST_RD_TURN, ST_RECOVER: w_load_val = S_LOAD;
            default:                                                 w_load_val = '0;
        endcase
    end

    always_comb begin
        w_data_out = 8'h00;
        w_data_oe  = 1'b0;
        w_ale      = 1'b0;
        w_write    = 1'b1;
        w_read     = 1'b1;
        case (w_next_state)
            ST_ALE_HI: begin
                w_data_out = w_addr;
                w_data_oe  = 1'b1;
                w_ale      = 1'b1;
            end
            ST_ALE_HOLD: begin
                w_data_out = w_addr;
                w_data_oe  = 1'b1;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                w_data_out = w_wdata;
                w_data_oe  = 1'b1;
            end
            ST_WR_LOW: begin
                w_data_out = w_wdata;
                w_data_oe  = 1'b1;
                w_write    = 1'b0;
            end
            ST_RD_LOW: w_read = 1'b0;
            default: ;
        endcase
    end

    bh_phase_timer #(
        .MAX_COUNT (MAX_COUNT)
    ) u_timer (
        .i_clk      (__osc),
        .i_rst_n    (__rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge __osc or negedge __rst_n) begin
        if (!__rst_n) begin
            r_state        <= ST_IDLE;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_bus_data_out <= 8'h00;
            r_bus_data_oe  <= 1'b0;
            r_bus_ale      <= 1'b0;
            r_bus_write    <= 1'b1;
            r_bus_read     <= 1'b1;
        end else begin
            r_state        <= w_next_state;
            r_req_ready    <= (w_next_state == ST_IDLE);
            r_rsp_valid    <= (w_next_state == ST_DONE);
            r_bus_data_out <= w_data_out;
            r_bus_data_oe  <= w_data_oe;
            r_bus_ale      <= w_ale;
            r_bus_write    <= w_write;
            r_bus_read     <= w_read;
        end
    end

    always_ff @(posedge __osc or negedge __rst_n) begin
        if (!__rst_n) begin
            r_op_write    <= 1'b0;
            r_op_addr     <= 8'h00;
            r_op_wdata    <= 8'h00;
            r_cache_valid <= 1'b0;
            r_cache_addr  <= 8'h00;
            r_rsp_rdata   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_op_write <= req_write;
                r_op_addr  <= req_addr;
                r_op_wdata <= req_wdata;
            end
            if (r_state == ST_ALE_HOLD && w_timer_done) begin
                r_cache_valid <= 1'b1;
                r_cache_addr  <= r_op_addr;
            end
            // The responder has driven data for at least one full clock by the end of RD_LOW.
            if (r_state == ST_RD_LOW && w_timer_done) begin
                r_rsp_rdata <= bus_data_in;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign bus_data_out = r_bus_data_out;
    assign bus_data_oe  = r_bus_data_oe;
    assign bus_ale      = r_bus_ale;
    assign bus_write    = r_bus_write;
    assign bus_read     = r_bus_read;

endmodule

// File: tb/tb_bottomhalf_bus_master.sv
// tb/tb_bottomhalf_bus_master.sv - directed and random checks of the bus master against responder models
module tb_bottomhalf_bus_master;

    localparam int P0 = 2;
    localparam int S0 = 1;
    localparam int P1 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic [7:0] bus_data_out [2];
    logic       bus_data_oe  [2];
    logic [7:0] bus_data_in  [2];
    logic       bus_ale   [2];
    logic       bus_write [2];
    logic       bus_read  [2];

    bottomhalf_bus_master #(
        .PULSE_CYCLES (P0), .SETUP_CYCLES (S0), .ADDR_CACHE (1)
    ) u_dut0 (
        .__osc (clk), .__rst_n (rst_n),
        .req_valid (req_valid[0]), .req_ready (req_ready[0]), .req_write (req_write[0]),
        .req_addr (req_addr[0]), .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]), .rsp_rdata (rsp_rdata[0]),
        .bus_data_out (bus_data_out[0]), .bus_data_oe (bus_data_oe[0]), .bus_data_in (bus_data_in[0]),
        .bus_ale (bus_ale[0]), .bus_write (bus_write[0]), .bus_read (bus_read[0])
    );

    bottomhalf_bus_master #(
        .PULSE_CYCLES (P1), .SETUP_CYCLES (S1), .ADDR_CACHE (0)
    ) u_dut1 (
        .__osc (clk), .__rst_n (rst_n),
        .req_valid (req_valid[1]), .req_ready (req_ready[1]), .req_write (req_write[1]),
        .req_addr (req_addr[1]), .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]), .rsp_rdata (rsp_rdata[1]),
        .bus_data_out (bus_data_out[1]), .bus_data_oe (bus_data_oe[1]), .bus_data_in (bus_data_in[1]),
        .bus_ale (bus_ale[1]), .bus_write (bus_write[1]), .bus_read (bus_read[1])
    );

    // Responder models: latch address on ALE fall, store on WRITE rise, drive while READ low.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ra0, ra1;

    function automatic logic [7:0] id_or_mem(input logic [7:0] a, input logic [7:0] m);
        case (a)
            8'hFD:   return 8'h34;
            8'hFE:   return 8'h12;
            8'hFF:   return 8'h07;
            default: return m;
        endcase
    endfunction

    always @(negedge bus_ale[0]) ra0 <= bus_data_out[0];
    always @(negedge bus_ale[1]) ra1 <= bus_data_out[1];
    always @(posedge bus_write[0]) mem0[ra0] <= bus_data_out[0];
    always @(posedge bus_write[1]) mem1[ra1] <= bus_data_out[1];
    assign bus_data_in[0] = bus_read[0] ? 8'hEE : id_or_mem(ra0, mem0[ra0]);
    assign bus_data_in[1] = bus_read[1] ? 8'hEE : id_or_mem(ra1, mem1[ra1]);

    // Bus monitor: pulse widths, pulse counts, strobe overlap, oe against read.
    int         pw [2] = '{P0, P1};
    int         ps [2] = '{S0, S1};
    int         ac [2] = '{1, 0};
    int         ale_run [2], wr_run [2], rd_run [2];
    int         ale_pulses [2], wr_pulses [2], rd_pulses [2];
    int         width_bad [2], overlap_bad [2], oe_rd_bad [2];
    int         rsp_cnt [2], acc_cnt [2];
    logic [7:0] ale_data [2], wr_data [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            ale_run[d] = 0; wr_run[d] = 0; rd_run[d] = 0;
            ale_pulses[d] = 0; wr_pulses[d] = 0; rd_pulses[d] = 0;
            width_bad[d] = 0; overlap_bad[d] = 0; oe_rd_bad[d] = 0;
            rsp_cnt[d] = 0; acc_cnt[d] = 0;
            ale_data[d] = 8'h00; wr_data[d] = 8'h00;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d]) rsp_cnt[d] <= rsp_cnt[d] + 1;
            if (req_valid[d] && req_ready[d] && rst_n) acc_cnt[d] <= acc_cnt[d] + 1;
            if (!rst_n) begin
                ale_run[d] <= 0; wr_run[d] <= 0; rd_run[d] <= 0;
            end else begin
                if (bus_ale[d]) begin
                    ale_run[d] <= ale_run[d] + 1; ale_data[d] <= bus_data_out[d];
                end else if (ale_run[d] != 0) begin
                    ale_pulses[d] <= ale_pulses[d] + 1; ale_run[d] <= 0;
                    if (ale_run[d] != pw[d]) width_bad[d] <= width_bad[d] + 1;
                end
                if (!bus_write[d]) begin
                    wr_run[d] <= wr_run[d] + 1; wr_data[d] <= bus_data_out[d];
                end else if (wr_run[d] != 0) begin
                    wr_pulses[d] <= wr_pulses[d] + 1; wr_run[d] <= 0;
                    if (wr_run[d] != pw[d]) width_bad[d] <= width_bad[d] + 1;
                end
                if (!bus_read[d]) begin
                    rd_run[d] <= rd_run[d] + 1;
                end else if (rd_run[d] != 0) begin
                    rd_pulses[d] <= rd_pulses[d] + 1; rd_run[d] <= 0;
                    if (rd_run[d] != pw[d]) width_bad[d] <= width_bad[d] + 1;
                end
                if (int'(bus_ale[d]) + int'(!bus_write[d]) + int'(!bus_read[d]) > 1)
                    overlap_bad[d] <= overlap_bad[d] + 1;
                if (bus_data_oe[d] && !bus_read[d]) oe_rd_bad[d] <= oe_rd_bad[d] + 1;
            end
        end
    end

    typedef struct {
        bit         wr;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;
    bit         cache_v [2];
    logic [7:0] cache_a [2];
    logic [7:0] exp_mem [2][256];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input int d, input logic [7:0] a);
        return id_or_mem(a, exp_mem[d][a]);
    endfunction

    task automatic run_req(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        bit   ap;
        int   lat, a0, w0, r0;
        exp_t e, got;
        ap = (ac[d] == 0) || !cache_v[d] || (cache_a[d] != a);
        cache_v[d] = 1'b1;
        cache_a[d] = a;
        if (wr) exp_mem[d][a] = wd;
        e.wr    = wr;
        e.rdata = wr ? 8'h00 : exp_rd(d, a);
        e.lat   = ap ? 2 * pw[d] + 3 * ps[d] : pw[d] + 2 * ps[d];
        sb.push_back(e);
        @(posedge clk); #2;
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
        @(negedge clk);
        chk("ready_idle", int'(req_ready[d]), 1);
        a0 = ale_pulses[d]; w0 = wr_pulses[d]; r0 = rd_pulses[d];
        @(posedge clk); #2;
        req_valid[d] = 1'b0; req_write[d] = !wr; req_addr[d] = ~a; req_wdata[d] = ~wd;
        lat = 0;
        @(negedge clk);
        chk("ready_busy", int'(req_ready[d]), 0);
        while (!rsp_valid[d] && lat < 200) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        got = sb.pop_front();
        chk("latency", lat, got.lat);
        if (!got.wr) chk("rdata", int'(rsp_rdata[d]), int'(got.rdata));
        chk("ale_pulses", ale_pulses[d] - a0, int'(ap));
        chk("wr_pulses", wr_pulses[d] - w0, int'(wr));
        chk("rd_pulses", rd_pulses[d] - r0, int'(!wr));
    endtask

    initial begin
        logic [7:0] wlist [$];
        logic [7:0] a;
        bit         wr;
        int         n, r0, a0, per;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 8'h00; req_wdata[d] = 8'h00;
            cache_v[d] = 1'b0; cache_a[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(req_ready[0]), 1);
        chk("rst_ale", int'(bus_ale[0]), 0);
        chk("rst_write", int'(bus_write[0]), 1);
        chk("rst_read", int'(bus_read[0]), 1);
        chk("rst_oe", int'(bus_data_oe[0]), 0);
        chk("rst_dout", int'(bus_data_out[0]), 0);
        chk("rst_rsp_valid", int'(rsp_valid[0]), 0);
        chk("rst_rdata", int'(rsp_rdata[0]), 0);
        chk("rst_ready1", int'(req_ready[1]), 1);

        // Write 0x12 <= 0xA5 with address phase, then read back through the bus
        run_req(0, 1'b1, 8'h12, 8'hA5);
        chk("ale_bus_addr", int'(ale_data[0]), 8'h12);
        chk("wr_bus_data", int'(wr_data[0]), 8'hA5);
        chk("resp_reg_12", int'(mem0[8'h12]), 8'hA5);
        run_req(0, 1'b0, 8'hFD, 8'h00);
        run_req(0, 1'b0, 8'h12, 8'h00);

        // Address cache: back-to-back to 0x13
        run_req(0, 1'b1, 8'h13, 8'h5A);
        run_req(0, 1'b1, 8'h13, 8'hC3);
        run_req(0, 1'b0, 8'h13, 8'h00);
        run_req(1, 1'b1, 8'h13, 8'h11);
        run_req(1, 1'b1, 8'h13, 8'h22);

        // Reset during WR_LOW
        r0 = rsp_cnt[0];
        @(posedge clk); #2;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h40; req_wdata[0] = 8'h99;
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus_write[0] !== 1'b0 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("wr_low_reached", int'(bus_write[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_write", int'(bus_write[0]), 1);
        chk("abort_oe", int'(bus_data_oe[0]), 0);
        chk("abort_ale", int'(bus_ale[0]), 0);
        chk("abort_ready", int'(req_ready[0]), 1);
        chk("abort_dout", int'(bus_data_out[0]), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        cache_v[0] = 1'b0; cache_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt[0] - r0, 0);
        run_req(0, 1'b1, 8'h40, 8'h66);
        run_req(0, 1'b0, 8'h40, 8'h00);

        // P=1, S=3 random traffic
        for (int i = 0; i < 24; i++) begin
            wr = (wlist.size() == 0) || ($urandom_range(0, 1) == 1);
            if (wr) begin
                a = 8'($urandom_range(0, 252));
                run_req(1, 1'b1, a, 8'($urandom_range(0, 255)));
                wlist.push_back(a);
            end else begin
                if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(253, 255));
                else                           a = wlist[$urandom_range(0, wlist.size() - 1)];
                run_req(1, 1'b0, a, 8'h00);
            end
        end

        // req_valid held high: one acceptance per completion, one per (latency + 1) cycles
        per = 2 * P1 + 3 * S1 + 2;
        @(posedge clk); #2;
        a0 = acc_cnt[1]; r0 = rsp_cnt[1];
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h55; req_wdata[1] = 8'h77;
        repeat (3 * per) @(posedge clk);
        #2 req_valid[1] = 1'b0;
        repeat (3 * per) @(negedge clk);
        chk("hold_accepts", acc_cnt[1] - a0, 3);
        chk("hold_completions", rsp_cnt[1] - r0, 3);
        chk("hold_ready", int'(req_ready[1]), 1);
        chk("hold_mem", int'(mem1[8'h55]), 8'h77);

        chk("width_bad0", width_bad[0], 0);
        chk("width_bad1", width_bad[1], 0);
        chk("overlap0", overlap_bad[0], 0);
        chk("overlap1", overlap_bad[1], 0);
        chk("oe_during_read0", oe_rd_bad[0], 0);
        chk("oe_during_read1", oe_rd_bad[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
